// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: retires one multiplier bit per clock.
// The start/ready handshake accepts operands. The product appears N cycles
// later together with a one-cycle done pulse.
// Optional build macro SEQ_SHIFT_ADD_MULT_SIGNED_EN selects two's-complement
// operands. When it is undefined, the operands are unsigned.
module seq_shift_add_mult #(
   parameter int unsigned M = 8,
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [M-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic           ready_o,
   output logic           busy_o,
   output logic           done_o,
   output logic [M+N-1:0] p_o
);

   localparam int unsigned W    = M + N;
   localparam int unsigned CntW = $clog2(N + 1);

   typedef enum logic {StIdle, StCalc} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    p_q, p_d;
   logic            done_q, done_d;

   logic [W-1:0]    a_ext;
   logic [W-1:0]    pp;
   logic [W-1:0]    sum;
   logic            last;

`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
   assign a_ext = {{N{a_i[M-1]}}, a_i};
`else
   assign a_ext = {{N{1'b0}}, a_i};
`endif

   assign pp   = a_q << cnt_q;
   assign last = (cnt_q == CntW'(N - 1));

   // Accumulate the current partial product; the sign bit's weight is negative when signed.
   always_comb begin
      sum = acc_q;
      if (b_q[0]) begin
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
         if (last) sum = acc_q - pp;
         else      sum = acc_q + pp;
`else
         sum = acc_q + pp;
`endif
      end
   end

   // Next-state logic: capture operands on accepted start, iterate N bits, publish on last.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StCalc;
               a_d     = a_ext;
               b_d     = b_i;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         StCalc: begin
            acc_d = sum;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
               state_d = StIdle;
               p_d     = sum;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; asynchronous reset aborts any calculation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = (state_q == StCalc);
   assign ready_o = ~busy_o;
   assign done_o  = done_q;
   assign p_o     = p_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed, table-driven bench for seq_shift_add_mult with M=N=8.
// It follows SEQ_SHIFT_ADD_MULT_SIGNED_EN in the same way as the design.
module tb_seq_shift_add_mult;

   localparam int N = 8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] p;

   int n_vec = 0;
   int n_err = 0;

   seq_shift_add_mult #(.M(8), .N(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .ready_o (ready),
      .busy_o  (busy),
      .done_o  (done),
      .p_o     (p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
      logic signed [15:0] sx, sy;
      sx = $signed({{8{x[7]}}, x});
      sy = $signed({{8{y[7]}}, y});
      return 16'(sx * sy);
`else
      return {8'd0, x} * {8'd0, y};
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one operation starting from an idle cycle; returns product, latency and ready glitches.
   task automatic do_op(input logic [7:0] xa, input logic [7:0] xb,
                        output logic [15:0] res, output int lat, output int rdy_hi);
      start = 1'b1;
      a     = xa;
      b     = xb;
      tick();
      start  = 1'b0;
      lat    = 0;
      rdy_hi = 0;
      while (!done && lat < 40) begin
         if (ready) rdy_hi++;
         tick();
         lat++;
      end
      res = p;
   endtask

   vec_t        vecs[$];
   logic [15:0] res, hold;
   int          lat, rdy_hi, cyc, dcnt;
   logic [7:0]  pa, pb;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
      vecs.push_back('{8'h80, 8'h80, 16'h4000});
      vecs.push_back('{8'hFF, 8'h01, 16'hFFFF});
      vecs.push_back('{8'h7F, 8'h80, 16'hC080});
      vecs.push_back('{8'hFD, 8'h05, 16'hFFF1});
      vecs.push_back('{8'hFF, 8'hFF, 16'h0001});
      vecs.push_back('{8'h00, 8'hFF, 16'h0000});
      vecs.push_back('{8'h03, 8'h05, 16'h000F});
`else
      vecs.push_back('{8'hFF, 8'hFF, 16'hFE01});
      vecs.push_back('{8'h5A, 8'h00, 16'h0000});
      vecs.push_back('{8'h00, 8'hC3, 16'h0000});
      vecs.push_back('{8'h03, 8'h05, 16'h000F});
      vecs.push_back('{8'hC8, 8'h64, 16'd20000});
      vecs.push_back('{8'h80, 8'h02, 16'h0100});
      vecs.push_back('{8'hAB, 8'hCD, 16'h88EF});
      vecs.push_back('{8'h01, 8'h01, 16'h0001});
`endif

      #2;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_p", 32'(p), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Table-driven operations with latency, pulse width and hold checks.
      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].a, vecs[i].b, res, lat, rdy_hi);
         chk($sformatf("vec%0d_p", i), 32'(res), 32'(vecs[i].p));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(N));
         chk($sformatf("vec%0d_rdy_calc", i), 32'(rdy_hi), 32'd0);
         chk($sformatf("vec%0d_rdy_done", i), 32'(ready), 32'd1);
         tick();
         chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
         tick();
         chk($sformatf("vec%0d_p_hold", i), 32'(p), 32'(vecs[i].p));
      end

      // Start during CALC is ignored; start held in the done cycle is taken next edge.
      start = 1'b1; a = 8'd3; b = 8'd5;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; a = 8'd7; b = 8'd7;
      cyc = 0;
      while (!done && cyc < 40) begin tick(); cyc++; end
      chk("ign_p", 32'(p), 32'd15);
      chk("ign_lat", 32'(cyc), 32'(N - 2));
      chk("ign_ready_done", 32'(ready), 32'd1);
      tick();
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_p_hold", 32'(p), 32'd15);
      cyc = 0;
      while (!done && cyc < 40) begin tick(); cyc++; end
      chk("b2b_p", 32'(p), 32'd49);
      chk("b2b_lat", 32'(cyc), 32'(N));
      tick();

      // Reset mid-calculation aborts with no done and clears p.
      start = 1'b1; a = 8'd200; b = 8'd100;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("abort_p", 32'(p), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      tick();
      rst_n = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) dcnt++;
         tick();
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      chk("abort_p_after", 32'(p), 32'd0);
      do_op(8'd200, 8'd100, res, lat, rdy_hi);
      chk("after_abort_p", 32'(res), 32'(ref_mul(8'd200, 8'd100)));
      chk("after_abort_lat", 32'(lat), 32'(N));
      tick();

      // Random back-to-back stream, each new start presented in the done cycle.
      pa = 8'($urandom);
      pb = 8'($urandom);
      start = 1'b1; a = pa; b = pb;
      for (int i = 0; i < 1000; i++) begin
         cyc = 0;
         do begin tick(); cyc++; end while (!done && cyc < 40);
         chk($sformatf("rnd%0d_p", i), 32'(p), 32'(ref_mul(pa, pb)));
         chk($sformatf("rnd%0d_spacing", i), 32'(cyc), 32'(N + 1));
         pa = 8'($urandom);
         pb = 8'($urandom);
         a  = pa;
         b  = pb;
      end
      start = 1'b0;
      hold = p;
      repeat (N + 3) tick();
      chk("final_idle", 32'(busy), 32'd0);
      chk("final_hold", 32'(p), 32'(hold));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
